// File: rtl/brq_mem_pkg.sv
// Shared types and helpers for the Buraq data-memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package brq_mem_pkg;

    // Access-size codes as carried on the load/store funct3 field.
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } brq_size_e;

    // Byte address of the MMIO output word: top word of the default 15-bit space.
    localparam logic [31:0] MMIO_IO_ADDR = 32'h0000_7FFC;

    // Natural-alignment check: halfwords on even bytes, words on word boundaries.
    function automatic logic brq_misaligned(input logic [2:0] size, input logic [1:0] addr_lsb);
        case (size)
            SZ_H, SZ_HU: return addr_lsb[0];
            SZ_W:        return (addr_lsb != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Legal size codes; unsigned variants only make sense for loads.
    function automatic logic brq_size_ok(input logic [2:0] size, input logic is_write);
        case (size)
            SZ_B, SZ_H, SZ_W: return 1'b1;
            SZ_BU, SZ_HU:     return ~is_write;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/brq_dmem_lane_align.sv
// Byte-lane steering: store mask/replication and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from whatever is presented.
module brq_dmem_lane_align (
    input  logic [2:0]  i_wr_size,
    input  logic [1:0]  i_wr_lsb,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata_rep,
    input  logic [2:0]  i_rd_size,
    input  logic [1:0]  i_rd_lsb,
    input  logic [31:0] i_rd_word,
    output logic [31:0] o_rdata
);
    import brq_mem_pkg::*;

    logic [31:0] w_shifted;

    // Store side: pick the lanes touched and replicate the right-justified data across them.
    always_comb begin
        o_wmask     = 4'b0000;
        o_wdata_rep = i_wdata;
        case (i_wr_size)
            SZ_B: begin
                o_wmask     = 4'b0001 << i_wr_lsb;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_wmask     = i_wr_lsb[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
            end
            SZ_W: o_wmask = 4'b1111;
            default: o_wmask = 4'b0000;
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend.
    always_comb begin
        w_shifted = i_rd_word >> {i_rd_lsb, 3'b000};
        case (i_rd_size)
            SZ_B:    o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_BU:   o_rdata = {24'h000000, w_shifted[7:0]};
            SZ_H:    o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            SZ_HU:   o_rdata = {16'h0000, w_shifted[15:0]};
            default: o_rdata = i_rd_word;
        endcase
    end

endmodule

// File: rtl/brq_dmem_responder.sv
// Data-memory responder: byte-write word RAM, extended loads, misalignment flagging; optional MMIO word under BRQ_DMEM_MMIO_EN.
// Latency: load data and rvalid/err appear the cycle after the request is sampled.
// Backpressure: none; one access accepted every cycle, reset cycles drop the access.
module brq_dmem_responder #(
    parameter int    DataWidth = 32,
    parameter int    AddrWidth = 15,
    // Memory image for the FPGA flow to attach to r_mem; the RTL does not load it itself.
    parameter string INIT_FILE = ""
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [AddrWidth-1:0] dmem_addr,
    input  logic [DataWidth-1:0] dmem_wdata,
    input  logic                 dmem_ren,
    input  logic                 dmem_wen,
    input  logic [2:0]           dmem_size,
    output logic [DataWidth-1:0] dmem_rdata,
    output logic                 dmem_rvalid,
    output logic                 dmem_err,
    output logic [DataWidth-1:0] dmem_io_out
);
    import brq_mem_pkg::*;

    localparam int IdxW  = AddrWidth - 2;
    localparam int Depth = 2 ** IdxW;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [DataWidth-1:0] r_ram_q;
    logic [DataWidth-1:0] r_rdata_hold;
    logic [2:0]           r_rd_size;
    logic [1:0]           r_rd_lsb;
    logic                 r_rd_mmio;
    logic                 r_rvalid;
    logic                 r_err;

    logic [IdxW-1:0]      w_idx;
    logic [1:0]           w_lsb;
    logic                 w_wr_req;
    logic                 w_rd_req;
    logic                 w_fault;
    logic                 w_wr_go;
    logic                 w_rd_go;
    logic                 w_ram_we;
    logic                 w_mmio_hit;
    logic [3:0]           w_wmask;
    logic [DataWidth-1:0] w_wdata_rep;
    logic [DataWidth-1:0] w_io_word;
    logic [DataWidth-1:0] w_rd_word;
    logic [DataWidth-1:0] w_load_data;

    assign w_idx    = dmem_addr[AddrWidth-1:2];
    assign w_lsb    = dmem_addr[1:0];
    // A write wins when both strobes are up; the read is simply not seen.
    assign w_wr_req = dmem_wen;
    assign w_rd_req = dmem_ren & ~dmem_wen;
    assign w_fault  = (w_wr_req | w_rd_req)
                    & (~brq_size_ok(dmem_size, w_wr_req) | brq_misaligned(dmem_size, w_lsb));
    assign w_wr_go  = w_wr_req & ~w_fault & ~brq_rst;
    assign w_rd_go  = w_rd_req & ~w_fault & ~brq_rst;
    assign w_ram_we = w_wr_go & ~w_mmio_hit;

    brq_dmem_lane_align u_align (
        .i_wr_size   (dmem_size),
        .i_wr_lsb    (w_lsb),
        .i_wdata     (dmem_wdata),
        .o_wmask     (w_wmask),
        .o_wdata_rep (w_wdata_rep),
        .i_rd_size   (r_rd_size),
        .i_rd_lsb    (r_rd_lsb),
        .i_rd_word   (w_rd_word),
        .o_rdata     (w_load_data)
    );

`ifdef BRQ_DMEM_MMIO_EN
    logic [DataWidth-1:0] r_io;

    assign w_mmio_hit = ({w_idx, 2'b00} == MMIO_IO_ADDR[AddrWidth-1:0]);

    // MMIO output word, written with the same lane mask as RAM.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_io <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_go && w_mmio_hit && w_wmask[i]) begin
                    r_io[i*8 +: 8] <= w_wdata_rep[i*8 +: 8];
                end
            end
        end
    end

    assign w_io_word   = r_io;
    assign dmem_io_out = r_io;
`else
    assign w_mmio_hit  = 1'b0;
    assign w_io_word   = '0;
    assign dmem_io_out = '0;
`endif

    // RAM byte-lane writes; kept reset-free so it maps onto block RAM.
    always_ff @(posedge brq_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we && w_wmask[i]) begin
                r_mem[w_idx][i*8 +: 8] <= w_wdata_rep[i*8 +: 8];
            end
        end
    end

    // Synchronous RAM read port, enabled only for accepted loads.
    always_ff @(posedge brq_clk) begin
        if (w_rd_go) begin
            r_ram_q <= r_mem[w_idx];
        end
    end

    // Read pipeline: remember how to extend, flag completion/fault, keep last load data.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rd_size    <= SZ_W;
            r_rd_lsb     <= 2'b00;
            r_rd_mmio    <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rvalid <= w_rd_go;
            r_err    <= w_fault;
            if (w_rd_go) begin
                r_rd_size <= dmem_size;
                r_rd_lsb  <= w_lsb;
                r_rd_mmio <= w_mmio_hit;
            end
            if (r_rvalid) begin
                r_rdata_hold <= w_load_data;
            end
        end
    end

    assign w_rd_word   = r_rd_mmio ? w_io_word : r_ram_q;
    assign dmem_rdata  = r_rvalid ? w_load_data : r_rdata_hold;
    assign dmem_rvalid = r_rvalid;
    assign dmem_err    = r_err;

endmodule

// File: tb/tb_brq_dmem_responder.sv
// Bench for brq_dmem_responder: vector table, reset corner sequence, randomized ops against a byte model.
// Latency: each access is checked one cycle after it is driven.
// Backpressure: none; expectations queue in order and pop as results appear.
module tb_brq_dmem_responder;
    import brq_mem_pkg::*;

    logic        brq_clk = 1'b0;
    logic        brq_rst;
    logic [14:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        dmem_err;
    logic [31:0] dmem_io_out;

    brq_dmem_responder #(.DataWidth(32), .AddrWidth(15), .INIT_FILE("")) dut (
        .brq_clk     (brq_clk),
        .brq_rst     (brq_rst),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ren    (dmem_ren),
        .dmem_wen    (dmem_wen),
        .dmem_size   (dmem_size),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .dmem_err    (dmem_err),
        .dmem_io_out (dmem_io_out)
    );

    always #5 brq_clk = ~brq_clk;

    typedef struct {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
        string       tag;
    } exp_t;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  size;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic        e_rvalid;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hold = 32'h0;
    logic [7:0]  mdl [16];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
        end
    endtask

    // Drive one access, queue what it should produce, then compare after the edge.
    task automatic cycle(input logic rst, input logic ren, input logic wen, input logic [2:0] size,
                         input logic [14:0] addr, input logic [31:0] wdata,
                         input logic e_rv, input logic e_err, input logic [31:0] e_rd, input string tag);
        exp_t e;
        exp_t got;
        @(negedge brq_clk);
        brq_rst    = rst;
        dmem_ren   = ren;
        dmem_wen   = wen;
        dmem_size  = size;
        dmem_addr  = addr;
        dmem_wdata = wdata;
        e.rvalid = e_rv;
        e.err    = e_err;
        e.rdata  = e_rd;
        e.tag    = tag;
        sb_q.push_back(e);
        @(posedge brq_clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, expected one entry", tag);
        end else begin
            got = sb_q.pop_front();
            check({got.tag, ".rvalid"}, {31'h0, dmem_rvalid}, {31'h0, got.rvalid});
            check({got.tag, ".err"},    {31'h0, dmem_err},    {31'h0, got.err});
            check({got.tag, ".rdata"},  dmem_rdata,           got.rdata);
            check({got.tag, ".io_out"}, dmem_io_out,          32'h0);
        end
        exp_hold = e_rd;
    endtask

    task automatic add_vec(input logic ren, input logic wen, input logic [2:0] size, input logic [14:0] addr,
                           input logic [31:0] wdata, input logic erv, input logic eerr, input logic [31:0] erd);
        vec_t v;
        v.ren = ren; v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
        v.e_rvalid = erv; v.e_err = eerr; v.e_rdata = erd;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] mdl_load(input int w, input int lsb, input logic [2:0] size);
        logic [7:0]  b;
        logic [15:0] h;
        b = mdl[w*4 + lsb];
        h = (lsb < 3) ? {mdl[w*4 + lsb + 1], mdl[w*4 + lsb]} : 16'h0;
        case (size)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return {mdl[w*4+3], mdl[w*4+2], mdl[w*4+1], mdl[w*4]};
        endcase
    endfunction

    initial begin
        brq_rst = 1'b1; dmem_ren = 1'b0; dmem_wen = 1'b0;
        dmem_size = 3'b000; dmem_addr = '0; dmem_wdata = '0;

        //      ren   wen   size    addr      wdata         rvalid err   rdata
        add_vec(1'b0, 1'b1, SZ_W,   15'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0010, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
        add_vec(1'b0, 1'b1, SZ_B,   15'h0013, 32'h00000080, 1'b0, 1'b0, 32'hDEADBEEF);
        add_vec(1'b1, 1'b0, SZ_B,   15'h0013, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80);
        add_vec(1'b1, 1'b0, SZ_BU,  15'h0013, 32'h0,        1'b1, 1'b0, 32'h00000080);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0010, 32'h0,        1'b1, 1'b0, 32'h80ADBEEF);
        add_vec(1'b0, 1'b1, SZ_H,   15'h0011, 32'h00001234, 1'b0, 1'b1, 32'h80ADBEEF);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0010, 32'h0,        1'b1, 1'b0, 32'h80ADBEEF);
        add_vec(1'b1, 1'b1, SZ_W,   15'h0020, 32'h00000005, 1'b0, 1'b0, 32'h80ADBEEF);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0020, 32'h0,        1'b1, 1'b0, 32'h00000005);
        add_vec(1'b1, 1'b0, SZ_H,   15'h0012, 32'h0,        1'b1, 1'b0, 32'hFFFF80AD);
        add_vec(1'b1, 1'b0, SZ_HU,  15'h0012, 32'h0,        1'b1, 1'b0, 32'h000080AD);
        add_vec(1'b1, 1'b0, SZ_H,   15'h0010, 32'h0,        1'b1, 1'b0, 32'hFFFFBEEF);
        add_vec(1'b1, 1'b0, SZ_B,   15'h0011, 32'h0,        1'b1, 1'b0, 32'hFFFFFFBE);
        add_vec(1'b1, 1'b0, SZ_BU,  15'h0010, 32'h0,        1'b1, 1'b0, 32'h000000EF);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0012, 32'h0,        1'b0, 1'b1, 32'h000000EF);
        add_vec(1'b1, 1'b0, 3'b011, 15'h0010, 32'h0,        1'b0, 1'b1, 32'h000000EF);
        add_vec(1'b0, 1'b1, SZ_W,   15'h0014, 32'h11223344, 1'b0, 1'b0, 32'h000000EF);
        add_vec(1'b0, 1'b1, SZ_BU,  15'h0014, 32'h000000FF, 1'b0, 1'b1, 32'h000000EF);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0014, 32'h0,        1'b1, 1'b0, 32'h11223344);
        add_vec(1'b0, 1'b1, 3'b111, 15'h0014, 32'h0,        1'b0, 1'b1, 32'h11223344);
        add_vec(1'b0, 1'b0, SZ_W,   15'h0014, 32'h0,        1'b0, 1'b0, 32'h11223344);
        add_vec(1'b0, 1'b1, SZ_H,   15'h0016, 32'hFFFFCAFE, 1'b0, 1'b0, 32'h11223344);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0014, 32'h0,        1'b1, 1'b0, 32'hCAFE3344);
        add_vec(1'b0, 1'b1, SZ_B,   15'h0015, 32'h1234565A, 1'b0, 1'b0, 32'hCAFE3344);
        add_vec(1'b1, 1'b0, SZ_W,   15'h0014, 32'h0,        1'b1, 1'b0, 32'hCAFE5A44);
        add_vec(1'b0, 1'b1, SZ_H,   15'h7FFE, 32'h0000BEEF, 1'b0, 1'b0, 32'hCAFE5A44);
        add_vec(1'b1, 1'b0, SZ_HU,  15'h7FFE, 32'h0,        1'b1, 1'b0, 32'h0000BEEF);
        add_vec(1'b1, 1'b0, SZ_HU,  15'h0011, 32'h0,        1'b0, 1'b1, 32'h0000BEEF);

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, SZ_W, 15'h0, 32'h0, 1'b0, 1'b0, 32'h0, "reset");
        cycle(1'b1, 1'b0, 1'b0, SZ_W, 15'h0, 32'h0, 1'b0, 1'b0, 32'h0, "reset2");

        foreach (vecs[i]) begin
            cycle(1'b0, vecs[i].ren, vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                  vecs[i].e_rvalid, vecs[i].e_err, vecs[i].e_rdata, $sformatf("vec%0d", i));
        end

        // Access during reset is dropped and outputs clear.
        cycle(1'b0, 1'b0, 1'b1, SZ_W, 15'h0030, 32'h0F0F0F0F, 1'b0, 1'b0, exp_hold, "rst_pre_sw");
        cycle(1'b0, 1'b1, 1'b0, SZ_W, 15'h0030, 32'h0,        1'b1, 1'b0, 32'h0F0F0F0F, "rst_pre_lw");
        cycle(1'b1, 1'b0, 1'b1, SZ_W, 15'h0030, 32'hAAAA5555, 1'b0, 1'b0, 32'h0, "rst_sw_drop");
        cycle(1'b1, 1'b1, 1'b0, SZ_W, 15'h0030, 32'h0,        1'b0, 1'b0, 32'h0, "rst_lw_drop");
        cycle(1'b1, 1'b1, 1'b0, SZ_W, 15'h0031, 32'h0,        1'b0, 1'b0, 32'h0, "rst_err_drop");
        cycle(1'b0, 1'b1, 1'b0, SZ_W, 15'h0030, 32'h0,        1'b1, 1'b0, 32'h0F0F0F0F, "rst_post_lw");

        // Randomized traffic over words 0x40..0x4C against a byte model.
        for (int w = 0; w < 4; w++) begin
            logic [31:0] d;
            d = $urandom;
            {mdl[w*4+3], mdl[w*4+2], mdl[w*4+1], mdl[w*4]} = d;
            cycle(1'b0, 1'b0, 1'b1, SZ_W, 15'(32'h40 + w*4), d, 1'b0, 1'b0, exp_hold, $sformatf("rinit%0d", w));
        end
        for (int k = 0; k < 60; k++) begin
            int          kind;
            int          w;
            int          lsb;
            int          si;
            logic [2:0]  sz;
            logic [31:0] d;
            kind = $urandom_range(0, 3);
            w    = $urandom_range(0, 3);
            si   = $urandom_range(0, 4);
            case (si)
                0: sz = SZ_B;
                1: sz = SZ_H;
                2: sz = SZ_W;
                3: sz = SZ_BU;
                default: sz = SZ_HU;
            endcase
            if (kind == 0 && sz == SZ_BU) sz = SZ_B;
            if (kind == 0 && sz == SZ_HU) sz = SZ_H;
            if (sz == SZ_B || sz == SZ_BU)      lsb = $urandom_range(0, 3);
            else if (sz == SZ_H || sz == SZ_HU) lsb = 2 * $urandom_range(0, 1);
            else                                lsb = 0;
            d = $urandom;
            if (kind == 0) begin
                if (sz == SZ_B) mdl[w*4+lsb] = d[7:0];
                else if (sz == SZ_H) {mdl[w*4+lsb+1], mdl[w*4+lsb]} = d[15:0];
                else {mdl[w*4+3], mdl[w*4+2], mdl[w*4+1], mdl[w*4]} = d;
                cycle(1'b0, 1'b0, 1'b1, sz, 15'(32'h40 + w*4 + lsb), d, 1'b0, 1'b0, exp_hold,
                      $sformatf("rnd%0d_wr", k));
            end else if (kind == 1) begin
                cycle(1'b0, 1'b1, 1'b0, sz, 15'(32'h40 + w*4 + lsb), d, 1'b1, 1'b0, mdl_load(w, lsb, sz),
                      $sformatf("rnd%0d_rd", k));
            end else if (kind == 2) begin
                cycle(1'b0, 1'b0, 1'b0, sz, 15'(32'h40 + w*4 + lsb), d, 1'b0, 1'b0, exp_hold,
                      $sformatf("rnd%0d_idle", k));
            end else begin
                // Odd byte offset: always misaligned for halfword and word.
                sz  = (si < 2) ? SZ_H : SZ_W;
                lsb = 2 * $urandom_range(0, 1) + 1;
                cycle(1'b0, 1'b1, 1'b0, sz, 15'(32'h40 + w*4 + lsb), d, 1'b0, 1'b1, exp_hold,
                      $sformatf("rnd%0d_mis", k));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
